dcs_rx_decoder: RTL and testbench
=================================

// Module: dcs_rx_decoder
// PURPOSE
//  Receive end of the DCS chain: accepts four 24-bit interleaved words, de-interleaves them and Viterbi-decodes the rate-1/2 code.
//  Hard-decision decode yields the 48-bit frame (32 data bits + 16 CRC bits).
//  Recomputes the CRC-16 (poly x^16+x^15+x^2+1, init 16'hFFFF) over the data bits and flags a match.
//  Sits after the channel, mirroring the DCS transmit path (CRC -> MUX -> FEC -> Interleaver).
// PARAMETERS
//  FRAME_BITS  48  decoded bits per frame (trellis steps)
//  DATA_BITS   32  payload bits covered by the CRC
//  PM_W        7   path-metric width; saturates at 2**PM_W-1
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  start      in   1   high in IDLE: capture inA..inD and begin decode
//  inA..inD   in   24  interleaved channel words (out0..out3 of the transmitter)
//  busy       out  1   high from capture until done
//  done       out  1   level; high once results are valid, cleared by next accepted start
//  data_out   out  32  decoded q0..q31, q0 at bit 31
//  crc_rx     out  16  decoded q32..q47, q32 at bit 15
//  crc_ok     out  1   recomputed CRC == crc_rx (valid while done)
//  path_metric out PM_W  winning path metric = corrected channel-bit count
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, metrics/survivors cleared; reset mid-decode aborts immediately.
//  De-interleave: pair p=4j+m (j=0..11, m=1..4) = in(4-m)[2j+1:2j], A=0..D=3; bit 2j+1=P1, bit 2j=P0.
//  Code model: pair k (k=1..48): P0=q[k-1]^q[k-2]^q[k-3]^q[k-4], P1=q[k-1]^q[k-3]^q[k-4]; q[<0]=0.
//  Trellis: 8 states S={newest,mid,oldest}. Transition {a,b,c}->{x,a,b}; expected P0=x^a^b^c, P1=x^b^c.
//  Branch metric = Hamming distance (0..2); metric add saturates at 2**PM_W-1.
//  Init metrics: state 0 = 0, all others = saturated.
//  ACS: one trellis step per cycle with all 8 states in parallel; survivor bit = c of winning predecessor.
//  ACS tie: the c=0 predecessor wins. Survivor RAM: 48 x 8 bits.
//  No tail bits: traceback starts at the lowest-metric final state (lowest index on tie); path_metric = that metric.
//  Traceback: at step k, state {x,a,b} emits q[k-1]=x, predecessor = {a,b,surv[k][state]}; run k=48 down to 1.
//  CRC: bit-serial over q0..q31 in order. fb=d^r[15]; r<={r[14:0],fb} ^ (fb ? 16'h8004 : 0).
//  FSM: IDLE -start-> ACS(48 cyc) -> TB(48 cyc) -> CRC(32 cyc) -> DONE. DONE -start-> ACS (restart); otherwise hold.
//  Latency: done rises on the 129th rising edge after the edge sampling start.
//  start while busy: ignored. Inputs need only be stable on the capture edge.
//  Outputs hold until the next accepted start; data_out/crc_rx/crc_ok/path_metric are 0 between capture and done.
// STRUCTURE
//  Package dcs_pkg: CRC_POLY=16'h8005, CRC_INIT=16'hFFFF, G0=4'b1111, G1=4'b1011, FRAME_BITS, DATA_BITS, FSM state enum.
//  Sub-module dcs_vit_acs: one combinational add-compare-select for a state pair.
//  Top instantiates 4 dcs_vit_acs butterflies; CRC, traceback and FSM stay in top.
// TESTING
//  1. Data 32'hDEADBEEF + golden CRC, encoded error-free -> done@129, data_out=DEADBEEF, crc_ok=1, path_metric=0.
//  2. Same frame, one channel bit flipped (inB[7]) -> data_out=DEADBEEF, crc_ok=1, path_metric=1.
//  3. Data 32'h0, crc bits flipped 16'h0001 at source -> crc_rx off by 1, crc_ok=0, path_metric=0.
//  4. Two flips in pairs 5 and 30 (>=12 pairs apart) -> corrected, path_metric=2, crc_ok=1.
//  5. start pulsed at cycle 60 while busy -> ignored, done still at 129, result from first capture.
//  6. reset_n low at cycle 70 -> all outputs 0 and IDLE immediately; new start decodes cleanly.

Source files
------------

// File: rtl/dcs_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dcs_pkg : constants, FSM states and code helpers for the DCS RX decoder
// Revision : 1.0
// ------------------------------------------------------------------
package dcs_pkg;

  localparam int          FRAME_BITS = 48;
  localparam int          DATA_BITS  = 32;
  localparam logic [15:0] CRC_POLY   = 16'h8005;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [3:0]  G0         = 4'b1111;
  localparam logic [3:0]  G1         = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACS  = 3'd1,
    ST_TB   = 3'd2,
    ST_CRC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Expected {P1,P0} for a branch whose shift register holds {x,a,b,c}.
  function automatic logic [1:0] code_pair(input logic [3:0] v);
    return {^(v & G1), ^(v & G0)};
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] r, input logic d);
    logic fb;
    fb = d ^ r[15];
    return {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcs_vit_acs.sv
`default_nettype none
// ------------------------------------------------------------------
// dcs_vit_acs : combinational add-compare-select butterfly for predecessors
//               {a,b,0}/{a,b,1} feeding successors {0,a,b}/{1,a,b}
// Revision : 1.0
// ------------------------------------------------------------------
module dcs_vit_acs
  import dcs_pkg::*;
#(
  parameter int PM_W = 7
) (
  input  logic [1:0]      ab,
  input  logic [1:0]      rx_pair,
  input  logic [PM_W-1:0] pm_c0,
  input  logic [PM_W-1:0] pm_c1,
  output logic [PM_W-1:0] pm_x0,
  output logic [PM_W-1:0] pm_x1,
  output logic            surv_x0,
  output logic            surv_x1
);

  function automatic logic [PM_W-1:0] add_bm(input logic [PM_W-1:0] pm,
                                             input logic [1:0]      exp_pair,
                                             input logic [1:0]      rx);
    logic [1:0]    diff;
    logic [PM_W:0] sum;
    diff = exp_pair ^ rx;
    sum  = {1'b0, pm} + {{PM_W{1'b0}}, diff[1]} + {{PM_W{1'b0}}, diff[0]};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // cand_<x><c>: metric into successor x via the predecessor with oldest bit c
  logic [PM_W-1:0] cand_00, cand_01, cand_10, cand_11;

  assign cand_00 = add_bm(pm_c0, code_pair({1'b0, ab, 1'b0}), rx_pair);
  assign cand_01 = add_bm(pm_c1, code_pair({1'b0, ab, 1'b1}), rx_pair);
  assign cand_10 = add_bm(pm_c0, code_pair({1'b1, ab, 1'b0}), rx_pair);
  assign cand_11 = add_bm(pm_c1, code_pair({1'b1, ab, 1'b1}), rx_pair);

  // Strict compare: on a tie the c=0 predecessor survives.
  assign surv_x0 = (cand_01 < cand_00);
  assign surv_x1 = (cand_11 < cand_10);
  assign pm_x0   = surv_x0 ? cand_01 : cand_00;
  assign pm_x1   = surv_x1 ? cand_11 : cand_10;

endmodule
`default_nettype wire

// File: rtl/dcs_rx_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// dcs_rx_decoder : de-interleave, hard-decision Viterbi decode and CRC-16 check
// Revision : 1.0
// ------------------------------------------------------------------
module dcs_rx_decoder
  import dcs_pkg::*;
#(
  parameter int PM_W = 7
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [23:0]                      inA,
  input  logic [23:0]                      inB,
  input  logic [23:0]                      inC,
  input  logic [23:0]                      inD,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_BITS-1:0]             data_out,
  output logic [FRAME_BITS-DATA_BITS-1:0]  crc_rx,
  output logic                             crc_ok,
  output logic [PM_W-1:0]                  path_metric
);

  localparam int              CRC_W     = FRAME_BITS - DATA_BITS;
  localparam logic [5:0]      LAST_STEP = 6'(FRAME_BITS - 1);
  localparam logic [5:0]      PUB_CNT   = 6'(DATA_BITS);
  localparam logic [PM_W-1:0] PM_MAX    = {PM_W{1'b1}};

  // Pair k (0-based) sits in word 3-(k%4) at bits [2(k/4)+1 : 2(k/4)].
  logic [3:0][23:0]           in_words;
  logic [FRAME_BITS-1:0][1:0] pair_in;

  assign in_words = {inD, inC, inB, inA};

  generate
    for (genvar k = 0; k < FRAME_BITS; k++) begin : g_deint
      assign pair_in[k] = in_words[3 - (k % 4)][2*(k/4) +: 2];
    end
  endgenerate

  state_e                     state_q, state_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [FRAME_BITS-1:0][1:0] rx_q, rx_d;
  logic [7:0][PM_W-1:0]       pm_q, pm_d;
  logic [FRAME_BITS-1:0][7:0] surv_q, surv_d;
  logic [2:0]                 tb_state_q, tb_state_d;
  logic [PM_W-1:0]            best_pm_q, best_pm_d;
  logic [FRAME_BITS-1:0]      dec_q, dec_d;
  logic [15:0]                crc_q, crc_d;
  logic                       done_q, done_d;
  logic [DATA_BITS-1:0]       data_q, data_d;
  logic [CRC_W-1:0]           crc_rx_q, crc_rx_d;
  logic                       crc_ok_q, crc_ok_d;
  logic [PM_W-1:0]            pm_out_q, pm_out_d;

  logic [7:0][PM_W-1:0]       acs_pm;
  logic [7:0]                 acs_surv;
  logic [1:0]                 step_pair;
  logic [2:0]                 best_state;
  logic [PM_W-1:0]            best_metric;

  assign step_pair = rx_q[cnt_q];

  generate
    for (genvar j = 0; j < 4; j++) begin : g_bfly
      dcs_vit_acs #(.PM_W(PM_W)) u_acs (
        .ab      (2'(j)),
        .rx_pair (step_pair),
        .pm_c0   (pm_q[2*j]),
        .pm_c1   (pm_q[2*j+1]),
        .pm_x0   (acs_pm[j]),
        .pm_x1   (acs_pm[j+4]),
        .surv_x0 (acs_surv[j]),
        .surv_x1 (acs_surv[j+4])
      );
    end
  endgenerate

  // Final-state selection runs on the last ACS outputs so traceback starts next cycle.
  always_comb begin
    best_state  = 3'd0;
    best_metric = acs_pm[0];
    for (int i = 1; i < 8; i++) begin
      if (acs_pm[i] < best_metric) begin
        best_state  = 3'(i);
        best_metric = acs_pm[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    pm_d       = pm_q;
    surv_d     = surv_q;
    tb_state_d = tb_state_q;
    best_pm_d  = best_pm_q;
    dec_d      = dec_q;
    crc_d      = crc_q;
    done_d     = done_q;
    data_d     = data_q;
    crc_rx_d   = crc_rx_q;
    crc_ok_d   = crc_ok_q;
    pm_out_d   = pm_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_ACS;
          cnt_d    = '0;
          rx_d     = pair_in;
          pm_d     = {8{PM_MAX}};
          pm_d[0]  = '0;
          crc_d    = CRC_INIT;
          done_d   = 1'b0;
          data_d   = '0;
          crc_rx_d = '0;
          crc_ok_d = 1'b0;
          pm_out_d = '0;
        end
      end
      ST_ACS: begin
        pm_d          = acs_pm;
        surv_d[cnt_q] = acs_surv;
        if (cnt_q == LAST_STEP) begin
          tb_state_d = best_state;
          best_pm_d  = best_metric;
          cnt_d      = '0;
          state_d    = ST_TB;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_TB: begin
        // dec holds q[i] at bit 47-i, so step k=48-cnt lands at bit cnt.
        dec_d[cnt_q] = tb_state_q[2];
        tb_state_d   = {tb_state_q[1:0], surv_q[LAST_STEP - cnt_q][tb_state_q]};
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = ST_CRC;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_CRC: begin
        if (cnt_q == PUB_CNT) begin
          data_d   = dec_q[FRAME_BITS-1 -: DATA_BITS];
          crc_rx_d = dec_q[CRC_W-1:0];
          crc_ok_d = (crc_q == dec_q[CRC_W-1:0]);
          pm_out_d = best_pm_q;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          crc_d = crc16_step(crc_q, dec_q[LAST_STEP - cnt_q]);
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      pm_q       <= '0;
      surv_q     <= '0;
      tb_state_q <= '0;
      best_pm_q  <= '0;
      dec_q      <= '0;
      crc_q      <= '0;
      done_q     <= 1'b0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      crc_ok_q   <= 1'b0;
      pm_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      pm_q       <= pm_d;
      surv_q     <= surv_d;
      tb_state_q <= tb_state_d;
      best_pm_q  <= best_pm_d;
      dec_q      <= dec_d;
      crc_q      <= crc_d;
      done_q     <= done_d;
      data_q     <= data_d;
      crc_rx_q   <= crc_rx_d;
      crc_ok_q   <= crc_ok_d;
      pm_out_q   <= pm_out_d;
    end
  end

  assign busy        = (state_q == ST_ACS) || (state_q == ST_TB) || (state_q == ST_CRC);
  assign done        = done_q;
  assign data_out    = data_q;
  assign crc_rx      = crc_rx_q;
  assign crc_ok      = crc_ok_q;
  assign path_metric = pm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_dcs_rx_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dcs_rx_decoder : directed frames with a queued scoreboard and done monitor
// Revision : 1.0
// ------------------------------------------------------------------
module tb_dcs_rx_decoder;

  localparam int PM_W    = 7;
  localparam int LATENCY = 129;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [23:0]     inA, inB, inC, inD;
  logic            busy, done, crc_ok;
  logic [31:0]     data_out;
  logic [15:0]     crc_rx;
  logic [PM_W-1:0] path_metric;

  dcs_rx_decoder #(.PM_W(PM_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .inA         (inA),
    .inB         (inB),
    .inC         (inC),
    .inD         (inD),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .crc_rx      (crc_rx),
    .crc_ok      (crc_ok),
    .path_metric (path_metric)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [15:0] crc;
    logic        ok;
    int          pm;
    int          start_edge;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   edges  = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", what, act, req);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [31:0] d);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      fb = d[i] ^ r[15];
      r  = {r[14:0], fb} ^ (fb ? 16'h8004 : 16'h0000);
    end
    return r;
  endfunction

  // Transmit-side model: rate-1/2 encode q0..q47, then interleave into {D,C,B,A}.
  function automatic logic [95:0] encode(input logic [31:0] d, input logic [15:0] c);
    logic [47:0]      q;
    logic [3:0]       h;
    logic [3:0][23:0] w;
    int               j, m;
    q = {d, c};
    w = '0;
    for (int k = 1; k <= 48; k++) begin
      for (int t = 1; t <= 4; t++) h[4-t] = (k - t >= 0) ? q[47 - (k - t)] : 1'b0;
      j = (k - 1) / 4;
      m = (k - 1) % 4 + 1;
      w[4-m][2*j+1] = h[3] ^ h[1] ^ h[0];
      w[4-m][2*j]   = ^h;
    end
    return w;
  endfunction

  task automatic send(input logic [23:0] a, b, c, d, input exp_t e, input bit push);
    exp_t ee;
    ee = e;
    @(negedge clk);
    inA = a; inB = b; inC = c; inD = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    ee.start_edge = edges;
    if (push) sb.push_back(ee);
    start = 1'b0;
    inA = 24'($urandom); inB = 24'($urandom); inC = 24'($urandom); inD = 24'($urandom);
    check($sformatf("f%0d_busy_after_start", e.id), busy, 1);
    check($sformatf("f%0d_done_cleared", e.id), done, 0);
    check($sformatf("f%0d_data_cleared", e.id), data_out, 0);
    check($sformatf("f%0d_pm_cleared", e.id), path_metric, 0);
  endtask

  task automatic wait_drain(input int id);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL f%0d_timeout: done not seen after %0d cycles, required by %0d", id, n, LATENCY);
      sb.delete();
    end
  endtask

  exp_t mon_e;
  logic done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at edge %0d, required no pending frame", edges);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("f%0d_latency", mon_e.id), edges - mon_e.start_edge, LATENCY);
          check($sformatf("f%0d_data", mon_e.id), data_out, mon_e.data);
          check($sformatf("f%0d_crc_rx", mon_e.id), crc_rx, mon_e.crc);
          check($sformatf("f%0d_crc_ok", mon_e.id), crc_ok, mon_e.ok);
          check($sformatf("f%0d_path_metric", mon_e.id), path_metric, mon_e.pm);
          check($sformatf("f%0d_busy_at_done", mon_e.id), busy, 0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] wa, wb, wc, wd;
    logic [15:0] c;
    exp_t        e;

    reset_n = 1'b0;
    start   = 1'b0;
    inA = '0; inB = '0; inC = '0; inD = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_outputs", {data_out, crc_rx, crc_ok, path_metric}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: error-free DEADBEEF
    c = crc_of(32'hDEADBEEF);
    {wd, wc, wb, wa} = encode(32'hDEADBEEF, c);
    e = '{data: 32'hDEADBEEF, crc: c, ok: 1'b1, pm: 0, start_edge: 0, id: 1};
    send(wa, wb, wc, wd, e, 1'b1);
    wait_drain(1);
    repeat (10) @(negedge clk);
    check("f1_done_holds", done, 1);
    check("f1_data_holds", data_out, 32'hDEADBEEF);

    // 2: single flipped channel bit
    {wd, wc, wb, wa} = encode(32'hDEADBEEF, c);
    wb[7] = ~wb[7];
    e = '{data: 32'hDEADBEEF, crc: c, ok: 1'b1, pm: 1, start_edge: 0, id: 2};
    send(wa, wb, wc, wd, e, 1'b1);
    wait_drain(2);

    // 3: corrupted CRC at the source
    c = crc_of(32'h0) ^ 16'h0001;
    {wd, wc, wb, wa} = encode(32'h0, c);
    e = '{data: 32'h0, crc: c, ok: 1'b0, pm: 0, start_edge: 0, id: 3};
    send(wa, wb, wc, wd, e, 1'b1);
    wait_drain(3);

    // 4: flips in pair 5 (inD[2]) and pair 30 (inC[15])
    c = crc_of(32'h12345678);
    {wd, wc, wb, wa} = encode(32'h12345678, c);
    wd[2]  = ~wd[2];
    wc[15] = ~wc[15];
    e = '{data: 32'h12345678, crc: c, ok: 1'b1, pm: 2, start_edge: 0, id: 4};
    send(wa, wb, wc, wd, e, 1'b1);
    wait_drain(4);

    // 5: start while busy must be ignored
    c = crc_of(32'hA5A50F0F);
    {wd, wc, wb, wa} = encode(32'hA5A50F0F, c);
    e = '{data: 32'hA5A50F0F, crc: c, ok: 1'b1, pm: 0, start_edge: 0, id: 5};
    send(wa, wb, wc, wd, e, 1'b1);
    repeat (60) @(negedge clk);
    {inD, inC, inB, inA} = encode(32'hFFFF0000, crc_of(32'hFFFF0000));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("f5_busy_after_second_start", busy, 1);
    wait_drain(5);

    // 6: reset mid-decode, then a clean frame
    c = crc_of(32'h13579BDF);
    {wd, wc, wb, wa} = encode(32'h13579BDF, c);
    e = '{data: 32'h13579BDF, crc: c, ok: 1'b1, pm: 0, start_edge: 0, id: 6};
    send(wa, wb, wc, wd, e, 1'b0);
    repeat (70) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("f6_reset_busy", busy, 0);
    check("f6_reset_done", done, 0);
    check("f6_reset_outputs", {data_out, crc_rx, crc_ok, path_metric}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("f6_idle_after_reset", busy, 0);
    c = crc_of(32'hCAFEF00D);
    {wd, wc, wb, wa} = encode(32'hCAFEF00D, c);
    e = '{data: 32'hCAFEF00D, crc: c, ok: 1'b1, pm: 0, start_edge: 0, id: 7};
    send(wa, wb, wc, wd, e, 1'b1);
    wait_drain(7);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
